// File: rtl/axi4_lite_cmd_queue.sv
// axi4_lite_cmd_queue: FIFO-buffered command sequencer keeping one AXI4-Lite transaction in flight.
// Define AXI_CMDQ_STATS_EN to build the saturating write/read/error response counters.
module axi4_lite_cmd_queue #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int STROB_WIDTH = 4,
   parameter int DEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [STROB_WIDTH-1:0]    cmd_strb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      write_en,
   output logic                      read_en,
   output logic [ADDR_WIDTH-1:0]     write_addr_in,
   output logic [ADDR_WIDTH-1:0]     read_addr_in,
   output logic [DATA_WIDTH-1:0]     write_data_in,
   output logic [STROB_WIDTH-1:0]    strobe_in,
   input  logic [DATA_WIDTH-1:0]     read_data_out,
   input  logic [1:0]                write_response_out,
   input  logic [1:0]                read_response_out,
   input  logic                      write_done,
   input  logic                      read_done,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      busy,
   output logic [15:0]               stat_wr,
   output logic [15:0]               stat_rd,
   output logic [15:0]               stat_err
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t r_state, w_next;
   logic                   r_fifo_write [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_fifo_addr  [DEPTH];
   logic [DATA_WIDTH-1:0]  r_fifo_wdata [DEPTH];
   logic [STROB_WIDTH-1:0] r_fifo_strb  [DEPTH];
   logic [PW-1:0]          r_wptr, r_rptr;
   logic [PW:0]            r_count;
   logic                   r_write;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
   logic [STROB_WIDTH-1:0] r_strb;
   logic [1:0]             r_resp;
   logic                   w_push, w_pop, w_done, w_rsp_hs;
   // cmd_ready depends only on the registered count, never on this cycle's pop
   assign cmd_ready = r_count != (PW+1)'(DEPTH);
   assign w_push    = cmd_valid & cmd_ready;
   assign w_pop     = (r_state == IDLE) & (r_count != '0) & ~rsp_valid;
   assign w_done    = r_write ? write_done : read_done;
   assign w_rsp_hs  = rsp_valid & rsp_ready;
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_write[r_wptr] <= cmd_write;
         r_fifo_addr[r_wptr]  <= cmd_addr;
         r_fifo_wdata[r_wptr] <= cmd_wdata;
         r_fifo_strb[r_wptr]  <= cmd_strb;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
         r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_pop ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = w_done ? RESP : WAIT;
         RESP:    w_next = rsp_ready ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
         r_rdata <= '0;
         r_resp  <= '0;
      end else begin
         if (w_pop) begin
            r_write <= r_fifo_write[r_rptr];
            r_addr  <= r_fifo_addr[r_rptr];
            r_wdata <= r_fifo_wdata[r_rptr];
            r_strb  <= r_fifo_strb[r_rptr];
         end
         if (r_state == WAIT && w_done) begin
            r_rdata <= r_write ? '0 : read_data_out;
            r_resp  <= r_write ? write_response_out : read_response_out;
         end
      end
   end
   assign write_en      = (r_state == ISSUE) & r_write;
   assign read_en       = (r_state == ISSUE) & ~r_write;
   assign write_addr_in = r_addr;
   assign read_addr_in  = r_addr;
   assign write_data_in = r_wdata;
   assign strobe_in     = r_strb;
   assign rsp_valid     = r_state == RESP;
   assign rsp_write     = r_write;
   assign rsp_rdata     = r_rdata;
   assign rsp_resp      = r_resp;
   assign fifo_count    = r_count;
   assign busy          = (r_state != IDLE) | (r_count != '0);
`ifdef AXI_CMDQ_STATS_EN
   logic [15:0] r_stat_wr, r_stat_rd, r_stat_err;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_wr  <= '0;
         r_stat_rd  <= '0;
         r_stat_err <= '0;
      end else if (w_rsp_hs) begin
         r_stat_wr  <= (r_write && r_stat_wr != 16'hFFFF) ? r_stat_wr + 1'b1 : r_stat_wr;
         r_stat_rd  <= (!r_write && r_stat_rd != 16'hFFFF) ? r_stat_rd + 1'b1 : r_stat_rd;
         r_stat_err <= (r_resp != 2'b00 && r_stat_err != 16'hFFFF) ? r_stat_err + 1'b1 : r_stat_err;
      end
   end
   assign stat_wr  = r_stat_wr;
   assign stat_rd  = r_stat_rd;
   assign stat_err = r_stat_err;
`else
   assign stat_wr  = '0;
   assign stat_rd  = '0;
   assign stat_err = '0;
`endif
endmodule
